pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 53 +++++
 rtl/pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Hazard/stall handshake bundle between the pipeline datapath
//               (master) and the pipeline controller (slave).
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef LOAD_NOPE
`define LOAD_NOPE 3'd0
`endif

interface pipe_ctrl_if;
    logic [2:0]  load_code_ex;
    logic        reg_wr_en_ex;
    logic [4:0]  addr_rd_ex;
    logic [4:0]  addr_rs1_id;
    logic [4:0]  addr_rs2_id;
    logic        rs1_used_id;
    logic        rs2_used_id;
    logic        jump_ex;
    logic        mdu_start;
    logic        mdu_done;
    logic        mem_req;
    logic        mem_ack;
    logic        hold_if_n;
    logic        hold_id_n;
    logic        hold_ex_n;
    logic        hold_mem_n;
    logic        flush_id;
    logic        flush_ex;
    logic        flush_mem;
    logic        mdu_timeout;
    logic [31:0] stall_cnt;

    modport master (
        output load_code_ex, reg_wr_en_ex, addr_rd_ex,
        output addr_rs1_id, addr_rs2_id, rs1_used_id, rs2_used_id,
        output jump_ex, mdu_start, mdu_done, mem_req, mem_ack,
        input  hold_if_n, hold_id_n, hold_ex_n, hold_mem_n,
        input  flush_id, flush_ex, flush_mem, mdu_timeout, stall_cnt
    );

    modport slave (
        input  load_code_ex, reg_wr_en_ex, addr_rd_ex,
        input  addr_rs1_id, addr_rs2_id, rs1_used_id, rs2_used_id,
        input  jump_ex, mdu_start, mdu_done, mem_req, mem_ack,
        output hold_if_n, hold_id_n, hold_ex_n, hold_mem_n,
        output flush_id, flush_ex, flush_mem, mdu_timeout, stall_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard controller: memory/mul-div stalls with a
//               mul/div watchdog, jump flushes and load-use bubbles.
//               Optional stall counter enabled by macro PIPE_STALL_CNT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MDU_WAIT = 2'd2
    } state_t;

    localparam logic [5:0] C_WD_LIMIT = 6'd63;

    state_t     r_state;
    state_t     w_next_state;
    logic [5:0] r_wd;
    logic       w_wd_clr;
    logic       w_wd_inc;

    logic       w_rs1_hit;
    logic       w_rs2_hit;
    logic       w_load_use;
    logic       w_mem_stall;

    logic       w_hold_if_n;
    logic       w_hold_id_n;
    logic       w_hold_ex_n;
    logic       w_hold_mem_n;
    logic       w_flush_id;
    logic       w_flush_ex;
    logic       w_flush_mem;
    logic       w_timeout;

    assign w_rs1_hit   = bus.rs1_used_id && (bus.addr_rs1_id == bus.addr_rd_ex);
    assign w_rs2_hit   = bus.rs2_used_id && (bus.addr_rs2_id == bus.addr_rd_ex);
    // x0 is never a real producer, so a load targeting it cannot create a hazard
    assign w_load_use  = (bus.load_code_ex != 3'(`LOAD_NOPE)) && bus.reg_wr_en_ex &&
                         (bus.addr_rd_ex != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_mem_stall = bus.mem_req && !bus.mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_hold_if_n  = 1'b1;
        w_hold_id_n  = 1'b1;
        w_hold_ex_n  = 1'b1;
        w_hold_mem_n = 1'b1;
        w_flush_id   = 1'b0;
        w_flush_ex   = 1'b0;
        w_flush_mem  = 1'b0;
        w_timeout    = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_inc     = 1'b0;

        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (w_mem_stall) begin
                        w_hold_if_n  = 1'b0;
                        w_hold_id_n  = 1'b0;
                        w_hold_ex_n  = 1'b0;
                        w_hold_mem_n = 1'b0;
                        w_next_state = ST_MEM_WAIT;
                    end else if (bus.mdu_start) begin
                        w_hold_if_n  = 1'b0;
                        w_hold_id_n  = 1'b0;
                        w_hold_ex_n  = 1'b0;
                        w_flush_mem  = 1'b1;
                        w_wd_clr     = 1'b1;
                        w_next_state = ST_MDU_WAIT;
                    end else if (bus.jump_ex) begin
                        w_flush_id   = 1'b1;
                        w_flush_ex   = 1'b1;
                    end else if (w_load_use) begin
                        w_hold_if_n  = 1'b0;
                        w_hold_id_n  = 1'b0;
                        w_flush_ex   = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!bus.mem_ack) begin
                        w_hold_if_n  = 1'b0;
                        w_hold_id_n  = 1'b0;
                        w_hold_ex_n  = 1'b0;
                        w_hold_mem_n = 1'b0;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_MDU_WAIT: begin
                    // A done in the watchdog's last cycle wins over the timeout
                    if (bus.mdu_done) begin
                        w_next_state = ST_RUN;
                    end else if (r_wd == C_WD_LIMIT) begin
                        w_timeout    = 1'b1;
                        w_next_state = ST_RUN;
                    end else begin
                        w_hold_if_n  = 1'b0;
                        w_hold_id_n  = 1'b0;
                        w_hold_ex_n  = 1'b0;
                        w_flush_mem  = 1'b1;
                        w_wd_inc     = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd <= 6'd0;
        end else if (w_wd_clr) begin
            r_wd <= 6'd0;
        end else if (w_wd_inc) begin
            r_wd <= r_wd + 6'd1;
        end
    end

    assign bus.hold_if_n   = w_hold_if_n;
    assign bus.hold_id_n   = w_hold_id_n;
    assign bus.hold_ex_n   = w_hold_ex_n;
    assign bus.hold_mem_n  = w_hold_mem_n;
    assign bus.flush_id    = w_flush_id;
    assign bus.flush_ex    = w_flush_ex;
    assign bus.flush_mem   = w_flush_mem;
    assign bus.mdu_timeout = w_timeout;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_any_hold;

    assign w_any_hold = !(w_hold_if_n && w_hold_id_n && w_hold_ex_n && w_hold_mem_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_any_hold) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl: directed scenarios plus
//               randomized traffic against a cycle-level behavioural model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef LOAD_NOPE
`define LOAD_NOPE 3'd0
`endif

module tb_pipe_ctrl;

`ifdef PIPE_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // Output vector: {hold_if,hold_id,hold_ex,hold_mem,flush_id,flush_ex,flush_mem,timeout}
    localparam logic [7:0] E_DEF = 8'b1111_0000;
    localparam logic [7:0] E_LU  = 8'b0011_0100;
    localparam logic [7:0] E_MEM = 8'b0000_0000;
    localparam logic [7:0] E_MDU = 8'b0001_0010;
    localparam logic [7:0] E_JMP = 8'b1111_1100;
    localparam logic [7:0] E_TMO = 8'b1111_0001;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {bus.hold_if_n, bus.hold_id_n, bus.hold_ex_n, bus.hold_mem_n,
                  bus.flush_id, bus.flush_ex, bus.flush_mem, bus.mdu_timeout};

    // Reference model state
    bit          m_mem_wait;
    int          m_mdu_age;
    logic [31:0] m_stalls;

    task automatic idle_inputs();
        bus.load_code_ex = `LOAD_NOPE;
        bus.reg_wr_en_ex = 1'b0;
        bus.addr_rd_ex   = 5'd0;
        bus.addr_rs1_id  = 5'd0;
        bus.addr_rs2_id  = 5'd0;
        bus.rs1_used_id  = 1'b0;
        bus.rs2_used_id  = 1'b0;
        bus.jump_ex      = 1'b0;
        bus.mdu_start    = 1'b0;
        bus.mdu_done     = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ack      = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        bus.load_code_ex = 3'd2;
        bus.reg_wr_en_ex = 1'b1;
        bus.addr_rd_ex   = rd;
        bus.addr_rs1_id  = rd;
        bus.rs1_used_id  = 1'b1;
        bus.addr_rs2_id  = 5'd7;
        bus.rs2_used_id  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        bus.mem_req   = 1'b1;
        bus.mdu_start = 1'b1;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL reset_outputs: got %b expected %b", obs, E_DEF);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== 32'd0) $display("FAIL reset_stall_cnt: got %0d expected 0", bus.stall_cnt);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL post_reset_idle: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_load_use();
        apply_reset();
        set_load_use(5'd5);
        settle();
        n_total++;
        if (obs !== E_LU) $display("FAIL load_use_rs1: got %b expected %b", obs, E_LU);
        else n_pass++;
        next_cycle();
        bus.load_code_ex = `LOAD_NOPE;
        bus.reg_wr_en_ex = 1'b0;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL load_use_release: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        set_load_use(5'd9);
        bus.addr_rs1_id = 5'd3;
        bus.addr_rs2_id = 5'd9;
        settle();
        n_total++;
        if (obs !== E_LU) $display("FAIL load_use_rs2: got %b expected %b", obs, E_LU);
        else n_pass++;
        next_cycle();
        bus.rs2_used_id = 1'b0;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL load_use_rs2_unused: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        set_load_use(5'd5);
        bus.reg_wr_en_ex = 1'b0;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL load_use_no_wr_en: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_load_x0();
        apply_reset();
        set_load_use(5'd0);
        bus.addr_rs2_id = 5'd0;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL load_x0: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_mem_stall();
        apply_reset();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            n_total++;
            if (obs !== E_MEM) $display("FAIL mem_stall_c%0d: got %b expected %b", i, obs, E_MEM);
            else n_pass++;
            next_cycle();
        end
        bus.mem_ack = 1'b1;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL mem_ack_release: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        idle_inputs();
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL mem_after_ack: got %b expected %b", obs, E_DEF);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== (CNT_EN ? 32'd3 : 32'd0))
            $display("FAIL mem_stall_cnt: got %0d expected %0d", bus.stall_cnt, CNT_EN ? 3 : 0);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_mdu_ignored();
        apply_reset();
        bus.mem_req = 1'b1;
        settle();
        next_cycle();
        bus.mdu_start = 1'b1;
        settle();
        n_total++;
        if (obs !== E_MEM) $display("FAIL mdu_in_mem_wait: got %b expected %b", obs, E_MEM);
        else n_pass++;
        next_cycle();
        bus.mdu_start = 1'b0;
        bus.mem_ack   = 1'b1;
        settle();
        next_cycle();
        idle_inputs();
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL mdu_start_ignored: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_mdu_done();
        apply_reset();
        bus.mdu_start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            n_total++;
            if (obs !== E_MDU) $display("FAIL mdu_busy_c%0d: got %b expected %b", i, obs, E_MDU);
            else n_pass++;
            next_cycle();
            bus.mdu_start = 1'b0;
        end
        bus.mdu_done = 1'b1;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL mdu_done_release: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        idle_inputs();
        settle();
        n_total++;
        if (bus.stall_cnt !== (CNT_EN ? 32'd10 : 32'd0))
            $display("FAIL mdu_stall_cnt: got %0d expected %0d", bus.stall_cnt, CNT_EN ? 10 : 0);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_mdu_timeout();
        int busy_bad;
        busy_bad = 0;
        apply_reset();
        bus.mdu_start = 1'b1;
        for (int i = 0; i < 64; i++) begin
            settle();
            if (obs !== E_MDU) begin
                if (busy_bad == 0) $display("FAIL mdu_wd_busy_c%0d: got %b expected %b", i, obs, E_MDU);
                busy_bad++;
            end
            next_cycle();
            bus.mdu_start = 1'b0;
        end
        n_total++;
        if (busy_bad != 0) $display("FAIL mdu_wd_busy_cycles: got %0d bad cycles expected 0", busy_bad);
        else n_pass++;
        settle();
        n_total++;
        if (obs !== E_TMO) $display("FAIL mdu_timeout_pulse: got %b expected %b", obs, E_TMO);
        else n_pass++;
        next_cycle();
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL mdu_timeout_single: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        bus.jump_ex = 1'b1;
        settle();
        n_total++;
        if (obs !== E_JMP) $display("FAIL mdu_timeout_back_to_run: got %b expected %b", obs, E_JMP);
        else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_jump_load();
        apply_reset();
        set_load_use(5'd5);
        bus.jump_ex = 1'b1;
        settle();
        n_total++;
        if (obs !== E_JMP) $display("FAIL jump_over_load_use: got %b expected %b", obs, E_JMP);
        else n_pass++;
        next_cycle();
        idle_inputs();
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL jump_one_cycle: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        bus.mem_req = 1'b1;
        settle();
        next_cycle();
        settle();
        n_total++;
        if (obs !== E_MEM) $display("FAIL rst_wait_pre: got %b expected %b", obs, E_MEM);
        else n_pass++;
        next_cycle();
        rst = 1'b1;
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL rst_mid_wait_release: got %b expected %b", obs, E_DEF);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        settle();
        n_total++;
        if (obs !== E_DEF) $display("FAIL rst_mid_wait_run: got %b expected %b", obs, E_DEF);
        else n_pass++;
        n_total++;
        if (bus.stall_cnt !== 32'd0) $display("FAIL rst_mid_wait_cnt: got %0d expected 0", bus.stall_cnt);
        else n_pass++;
        next_cycle();
    endtask

    function automatic bit exp_load_use();
        if (bus.load_code_ex == `LOAD_NOPE || !bus.reg_wr_en_ex || bus.addr_rd_ex == 5'd0)
            return 1'b0;
        return (bus.rs1_used_id && bus.addr_rs1_id == bus.addr_rd_ex) ||
               (bus.rs2_used_id && bus.addr_rs2_id == bus.addr_rd_ex);
    endfunction

    // Expected outputs for the current inputs; advances the model to the next cycle
    task automatic model_cycle(output logic [7:0] e);
        e = E_DEF;
        if (rst) begin
            m_mem_wait = 1'b0;
            m_mdu_age  = -1;
            m_stalls   = 32'd0;
            return;
        end
        if (m_mem_wait) begin
            if (bus.mem_ack) m_mem_wait = 1'b0;
            else e = E_MEM;
        end else if (m_mdu_age >= 0) begin
            m_mdu_age++;
            if (bus.mdu_done) m_mdu_age = -1;
            else if (m_mdu_age == 64) begin
                e = E_TMO;
                m_mdu_age = -1;
            end else e = E_MDU;
        end else if (bus.mem_req && !bus.mem_ack) begin
            e = E_MEM;
            m_mem_wait = 1'b1;
        end else if (bus.mdu_start) begin
            e = E_MDU;
            m_mdu_age = 0;
        end else if (bus.jump_ex) begin
            e = E_JMP;
        end else if (exp_load_use()) begin
            e = E_LU;
        end
        if (e[7:4] != 4'hF) m_stalls = m_stalls + 32'd1;
    endtask

    task automatic test_random();
        logic [7:0]  e;
        logic [31:0] e_cnt;
        bit          waiting;
        apply_reset();
        m_mem_wait = 1'b0;
        m_mdu_age  = -1;
        m_stalls   = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            waiting          = m_mem_wait || (m_mdu_age >= 0);
            rst              = ($urandom_range(0, 99) == 0);
            bus.addr_rd_ex   = 5'($urandom_range(0, 3));
            bus.addr_rs1_id  = 5'($urandom_range(0, 3));
            bus.addr_rs2_id  = 5'($urandom_range(0, 3));
            bus.rs1_used_id  = 1'($urandom_range(0, 1));
            bus.rs2_used_id  = 1'($urandom_range(0, 1));
            bus.reg_wr_en_ex = ($urandom_range(0, 3) != 0);
            bus.load_code_ex = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : `LOAD_NOPE;
            bus.jump_ex      = ($urandom_range(0, 4) == 0);
            bus.mem_req      = ($urandom_range(0, 5) == 0);
            bus.mem_ack      = ($urandom_range(0, 2) == 0);
            bus.mdu_start    = ($urandom_range(0, 9) == 0);
            bus.mdu_done     = ($urandom_range(0, 39) == 0);
            if (waiting) begin
                bus.jump_ex      = 1'b0;
                bus.load_code_ex = `LOAD_NOPE;
                bus.mem_req      = m_mem_wait;
            end
            settle();
            e_cnt = CNT_EN ? m_stalls : 32'd0;
            n_total++;
            if (bus.stall_cnt !== e_cnt)
                $display("FAIL rand_stall_cnt cyc %0d: got %0d expected %0d", cyc, bus.stall_cnt, e_cnt);
            else n_pass++;
            model_cycle(e);
            n_total++;
            if (obs !== e)
                $display("FAIL rand_outputs cyc %0d: got %b expected %b (rst=%0b req=%0b ack=%0b start=%0b done=%0b jump=%0b)",
                         cyc, obs, e, rst, bus.mem_req, bus.mem_ack, bus.mdu_start, bus.mdu_done, bus.jump_ex);
            else n_pass++;
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_load_x0();
        test_mem_stall();
        test_mdu_ignored();
        test_mdu_done();
        test_mdu_timeout();
        test_jump_load();
        test_reset_mid_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
